stopwatch_timer: RTL and testbench

- Parametrised successor to the board's mm:ss wall clock: single-clock, clock-enable based (no derived clocks), BCD mm:ss output for the 7-segment driver.
- Adds count-up/count-down modes, run/pause with preserved sub-second phase, lap-hold display freeze, preset load, a configurable minute range, countdown-expiry alarm and overflow flag.

---
 rtl/stopwatch_timer.sv | 199 +++++++++++++++++++
 tb/tb_stopwatch_timer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/stopwatch_timer.sv
// stopwatch_timer: BCD mm:ss stopwatch / countdown timer.
// Single clock; a 1 ms prescaler feeds a millisecond counter, which feeds the
// BCD seconds/minutes counter. Time_out and s_point form a registered display
// stage that can be frozen for lap timing.
module stopwatch_timer #(
   parameter int CLK_FREQ = 100_000_000,
   parameter int MAX_MIN  = 59,
   parameter bit BLINK    = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        run,
   input  logic        hold,
   input  logic        dir,
   input  logic        load,
   input  logic [15:0] preset,
   output logic [15:0] Time_out,
   output logic [3:0]  s_point,
   output logic        alarm,
   output logic        ovf,
   output logic        load_err
);

   localparam int TC = CLK_FREQ / 1000 - 1;
   localparam int PW = (TC < 1) ? 1 : $clog2(TC + 1);
   localparam logic [PW-1:0] TC_V      = PW'(TC);
   localparam logic [3:0]    MAX_T     = 4'(MAX_MIN / 10);
   localparam logic [3:0]    MAX_U     = 4'(MAX_MIN % 10);
   localparam logic [7:0]    MAX_MIN_V = 8'(MAX_MIN);

   logic [PW-1:0] presc_reg;
   logic [9:0]    ms_reg;
   logic [3:0]    sec_u_reg, sec_t_reg, min_u_reg, min_t_reg;
   logic          expired_reg;

   logic          presc_en, ms_tick, sec_tick;
   logic [3:0]    digit_ok;
   logic [7:0]    preset_min_bin;
   logic          load_ok;
   logic          at_max, is_zero, is_one;
   logic [3:0]    up_sec_u_next, up_sec_t_next, up_min_u_next, up_min_t_next;
   logic [3:0]    dn_sec_u_next, dn_sec_t_next, dn_min_u_next, dn_min_t_next;
   logic [1:0]    colon_next;

   // A countdown that has expired parks the prescaler so the phase stays put.
   assign presc_en = run && !(dir && expired_reg);
   assign ms_tick  = presc_en && (presc_reg == TC_V);
   assign sec_tick = ms_tick && (ms_reg == 10'd999);

   // Per-digit BCD legality of the preset.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_digit
         assign digit_ok[gi] = (preset[4*gi +: 4] <= 4'd9);
      end
   endgenerate

   assign preset_min_bin = {4'd0, preset[15:12]} * 8'd10 + {4'd0, preset[11:8]};
   assign load_ok = (&digit_ok) && (preset[7:4] <= 4'd5) && (preset_min_bin <= MAX_MIN_V);

   assign at_max  = (min_t_reg == MAX_T) && (min_u_reg == MAX_U) &&
                    (sec_t_reg == 4'd5) && (sec_u_reg == 4'd9);
   assign is_zero = (min_t_reg == 4'd0) && (min_u_reg == 4'd0) &&
                    (sec_t_reg == 4'd0) && (sec_u_reg == 4'd0);
   assign is_one  = (min_t_reg == 4'd0) && (min_u_reg == 4'd0) &&
                    (sec_t_reg == 4'd0) && (sec_u_reg == 4'd1);

   // Next BCD value for one second up (with range wrap) and one second down.
   always_comb begin
      up_sec_u_next = sec_u_reg;
      up_sec_t_next = sec_t_reg;
      up_min_u_next = min_u_reg;
      up_min_t_next = min_t_reg;
      if (at_max) begin
         up_sec_u_next = 4'd0;
         up_sec_t_next = 4'd0;
         up_min_u_next = 4'd0;
         up_min_t_next = 4'd0;
      end else if (sec_u_reg != 4'd9) begin
         up_sec_u_next = sec_u_reg + 4'd1;
      end else begin
         up_sec_u_next = 4'd0;
         if (sec_t_reg != 4'd5) begin
            up_sec_t_next = sec_t_reg + 4'd1;
         end else begin
            up_sec_t_next = 4'd0;
            if (min_u_reg != 4'd9) begin
               up_min_u_next = min_u_reg + 4'd1;
            end else begin
               up_min_u_next = 4'd0;
               up_min_t_next = min_t_reg + 4'd1;
            end
         end
      end

      dn_sec_u_next = sec_u_reg;
      dn_sec_t_next = sec_t_reg;
      dn_min_u_next = min_u_reg;
      dn_min_t_next = min_t_reg;
      if (sec_u_reg != 4'd0) begin
         dn_sec_u_next = sec_u_reg - 4'd1;
      end else begin
         dn_sec_u_next = 4'd9;
         if (sec_t_reg != 4'd0) begin
            dn_sec_t_next = sec_t_reg - 4'd1;
         end else begin
            dn_sec_t_next = 4'd5;
            if (min_u_reg != 4'd0) begin
               dn_min_u_next = min_u_reg - 4'd1;
            end else begin
               dn_min_u_next = 4'd9;
               dn_min_t_next = min_t_reg - 4'd1;
            end
         end
      end
   end

   // Colon pattern: steady when blinking is off, paused or expired.
   always_comb begin
      colon_next = 2'b11;
      if (BLINK && run && !expired_reg && (ms_reg >= 10'd500))
         colon_next = 2'b00;
   end

   // Counter state: reset > load > tick. Status pulses last one cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         presc_reg   <= '0;
         ms_reg      <= 10'd0;
         sec_u_reg   <= 4'd0;
         sec_t_reg   <= 4'd0;
         min_u_reg   <= 4'd0;
         min_t_reg   <= 4'd0;
         expired_reg <= 1'b0;
         alarm       <= 1'b0;
         ovf         <= 1'b0;
         load_err    <= 1'b0;
      end else begin
         alarm    <= 1'b0;
         ovf      <= 1'b0;
         load_err <= 1'b0;
         if (load) begin
            // A rejected load freezes everything for this cycle.
            if (load_ok) begin
               min_t_reg   <= preset[15:12];
               min_u_reg   <= preset[11:8];
               sec_t_reg   <= preset[7:4];
               sec_u_reg   <= preset[3:0];
               ms_reg      <= 10'd0;
               presc_reg   <= '0;
               expired_reg <= dir && (preset == 16'h0000);
            end else begin
               load_err <= 1'b1;
            end
         end else begin
            if (!dir)
               expired_reg <= 1'b0;
            if (presc_en)
               presc_reg <= ms_tick ? '0 : presc_reg + 1'b1;
            if (ms_tick)
               ms_reg <= (ms_reg == 10'd999) ? 10'd0 : ms_reg + 10'd1;
            if (sec_tick) begin
               if (!dir) begin
                  sec_u_reg <= up_sec_u_next;
                  sec_t_reg <= up_sec_t_next;
                  min_u_reg <= up_min_u_next;
                  min_t_reg <= up_min_t_next;
                  ovf       <= at_max;
               end else if (is_zero || is_one) begin
                  // No underflow: land on 00:00 and latch expiry.
                  sec_u_reg   <= 4'd0;
                  sec_t_reg   <= 4'd0;
                  min_u_reg   <= 4'd0;
                  min_t_reg   <= 4'd0;
                  expired_reg <= 1'b1;
                  alarm       <= 1'b1;
               end else begin
                  sec_u_reg <= dn_sec_u_next;
                  sec_t_reg <= dn_sec_t_next;
                  min_u_reg <= dn_min_u_next;
                  min_t_reg <= dn_min_t_next;
               end
            end
         end
      end
   end

   // Display register: follows the counter one cycle late unless held.
   always_ff @(posedge clk) begin
      if (reset) begin
         Time_out <= 16'h0000;
         s_point  <= 4'b1100;
      end else if (!hold) begin
         Time_out <= {min_t_reg, min_u_reg, sec_t_reg, sec_u_reg};
         s_point  <= {colon_next, 2'b00};
      end
   end

endmodule

// File: tb/tb_stopwatch_timer.sv
// Bench for stopwatch_timer with a 4 kHz clock (prescaler 0..3, 4000 clocks/s).
// Expected values are queued when stimulus is applied and popped at sampling.
module tb_stopwatch_timer;

   logic        clk = 1'b0;
   logic        reset, run, hold, dir, load;
   logic [15:0] preset;
   logic [15:0] Time_out;
   logic [3:0]  s_point;
   logic        alarm, ovf, load_err;

   stopwatch_timer #(.CLK_FREQ(4000), .MAX_MIN(59), .BLINK(1'b1)) dut (
      .clk(clk), .reset(reset), .run(run), .hold(hold), .dir(dir), .load(load),
      .preset(preset), .Time_out(Time_out), .s_point(s_point),
      .alarm(alarm), .ovf(ovf), .load_err(load_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      logic [15:0] val;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_errors = 0;
   int   alarm_cnt = 0;
   int   ovf_cnt = 0;
   int   a0, o0;

   // Pulse monitors, sampled after the edge has settled.
   always @(posedge clk) begin
      #2;
      if (alarm) alarm_cnt++;
      if (ovf)   ovf_cnt++;
   end

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end else begin
         $display("ok   %s: %h", tag, got);
      end
   endtask

   task automatic sb_push(input string tag, input logic [15:0] val);
      exp_t e;
      e.tag = tag;
      e.val = val;
      sb_q.push_back(e);
   endtask

   task automatic sb_pop(input logic [15:0] got);
      exp_t e;
      if (sb_q.size() == 0) begin
         chk("sb_underrun", got, 16'hxxxx);
      end else begin
         e = sb_q.pop_front();
         chk(e.tag, got, e.val);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_load(input logic [15:0] p);
      preset = p;
      load   = 1'b1;
      tick(1);
      load   = 1'b0;
   endtask

   logic [15:0] bad_tbl [4];

   initial begin
      reset = 1'b1; run = 1'b0; hold = 1'b0; dir = 1'b0; load = 1'b0; preset = 16'h0000;
      bad_tbl[0] = 16'h0060; bad_tbl[1] = 16'h6000; bad_tbl[2] = 16'h0A00; bad_tbl[3] = 16'h005A;

      // Reset state
      sb_push("rst_time", 16'h0000); sb_push("rst_sp", 16'h000C);
      sb_push("rst_pulses", 16'h0000);
      tick(2);
      sb_pop(Time_out); sb_pop({12'd0, s_point}); sb_pop({13'd0, alarm, ovf, load_err});

      // Free up-count from reset: first second and colon blink
      reset = 1'b0; run = 1'b1; dir = 1'b0;
      sb_push("sp_2000", 16'h000C);  tick(2000); sb_pop({12'd0, s_point});
      sb_push("sp_2001", 16'h0000);  tick(1);    sb_pop({12'd0, s_point});
      sb_push("t_4000", 16'h0000);   tick(1999); sb_pop(Time_out);
      sb_push("t_4001", 16'h0001);   sb_push("sp_4001", 16'h000C);
      tick(1); sb_pop(Time_out); sb_pop({12'd0, s_point});

      // Preset 59:58 and wrap with overflow
      o0 = ovf_cnt;
      pulse_load(16'h5958);
      sb_push("ld_5958", 16'h5958);  tick(1);    sb_pop(Time_out);
      sb_push("up_5959", 16'h5959);  tick(4000); sb_pop(Time_out);
      sb_push("ovf_at_wrap", 16'h0001); sb_push("pre_wrap", 16'h5959);
      tick(3999); sb_pop({15'd0, ovf}); sb_pop(Time_out);
      sb_push("wrap_0000", 16'h0000); sb_push("ovf_count", 16'h0001);
      tick(1); sb_pop(Time_out); sb_pop(16'(ovf_cnt - o0));

      // Countdown from 00:02 to expiry
      a0 = alarm_cnt;
      dir = 1'b1;
      pulse_load(16'h0002);
      sb_push("dn_0001", 16'h0001);  tick(4001); sb_pop(Time_out);
      sb_push("alarm_at_0", 16'h0001); tick(3999); sb_pop({15'd0, alarm});
      sb_push("dn_0000", 16'h0000);  sb_push("exp_sp", 16'h000C);
      tick(1); sb_pop(Time_out); sb_pop({12'd0, s_point});
      sb_push("exp_stay", 16'h0000); sb_push("alarm_count", 16'h0001);
      sb_push("exp_sp2", 16'h000C);
      tick(8000); sb_pop(Time_out); sb_pop(16'(alarm_cnt - a0)); sb_pop({12'd0, s_point});

      // Lap hold, then pause with preserved prescaler phase
      dir = 1'b0;
      pulse_load(16'h0010);
      sb_push("hold_base", 16'h0010); tick(1); sb_pop(Time_out);
      hold = 1'b1;
      sb_push("hold_frozen", 16'h0010); tick(12000); sb_pop(Time_out);
      hold = 1'b0;
      sb_push("hold_release", 16'h0013); tick(1); sb_pop(Time_out);
      run = 1'b0;
      sb_push("pause_time", 16'h0013); sb_push("pause_sp", 16'h000C);
      tick(5000); sb_pop(Time_out); sb_pop({12'd0, s_point});
      run = 1'b1;
      sb_push("resume_pre", 16'h0013); tick(3998); sb_pop(Time_out);
      sb_push("resume_0014", 16'h0014); tick(1); sb_pop(Time_out);

      // Rejected loads
      run = 1'b0;
      tick(1);
      for (int i = 0; i < 4; i++) begin
         pulse_load(bad_tbl[i]);
         sb_push($sformatf("lerr_%h", bad_tbl[i]), 16'h0001); sb_pop({15'd0, load_err});
         sb_push($sformatf("lerr_keep_%h", bad_tbl[i]), 16'h0014);
         tick(1); sb_pop(Time_out);
      end
      pulse_load(16'h5959);
      sb_push("ld_max_ok", 16'h0000); sb_pop({15'd0, load_err});
      sb_push("ld_max", 16'h5959); tick(1); sb_pop(Time_out);

      // Loading 00:00 while counting down expires silently
      a0 = alarm_cnt;
      dir = 1'b1;
      pulse_load(16'h0000);
      run = 1'b1;
      sb_push("ld0_time", 16'h0000); sb_push("ld0_noalarm", 16'h0000);
      sb_push("ld0_sp", 16'h000C);
      tick(4010); sb_pop(Time_out); sb_pop(16'(alarm_cnt - a0)); sb_pop({12'd0, s_point});
      dir = 1'b0;
      sb_push("up_after_exp", 16'h0001); tick(4010); sb_pop(Time_out);

      // Reset beats load in the same cycle
      reset = 1'b1; load = 1'b1; preset = 16'h0060;
      sb_push("rst_ld_lerr", 16'h0000); sb_push("rst_ld_time", 16'h0000);
      tick(1); sb_pop({15'd0, load_err}); sb_pop(Time_out);
      preset = 16'h1234;
      tick(1);
      reset = 1'b0; load = 1'b0; run = 1'b1; dir = 1'b0;
      sb_push("rst_wins", 16'h0000); tick(1); sb_pop(Time_out);

      // Load coinciding with a second tick: preset shown, no increment
      tick(3998);
      pulse_load(16'h0100);
      sb_push("ld_tick_pre", 16'h0000); sb_pop(Time_out);
      sb_push("ld_tick", 16'h0100); tick(1); sb_pop(Time_out);
      sb_push("ld_tick_next", 16'h0101); tick(4000); sb_pop(Time_out);

      if (sb_q.size() != 0) chk("sb_leftover", 16'(sb_q.size()), 16'h0000);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
